// File: rtl/run_detector_param.sv
// Detects runs of '1's with length in [MIN_RUN, MAX_RUN] terminated by a '0'.
// Reports the run length, flags over-long runs and counts detections (saturating).
module run_detector_param #(
    parameter int unsigned MIN_RUN = 3,
    parameter int unsigned MAX_RUN = 15,
    parameter int unsigned CNT_W   = 5,
    parameter int unsigned EVT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             clr_cnt,
    output logic             detected,
    output logic             overrun,
    output logic [CNT_W-1:0] run_len,
    output logic [EVT_W-1:0] det_count,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        StIdle     = 3'b000,
        StCount    = 3'b001,
        StArmed    = 3'b010,
        StOver     = 3'b011,
        StDetected = 3'b100
    } state_e;

    localparam logic [CNT_W-1:0] MinRun  = CNT_W'(MIN_RUN);
    localparam logic [CNT_W-1:0] MaxRun  = CNT_W'(MAX_RUN);
    localparam logic [CNT_W-1:0] RunOne  = CNT_W'(1);
    localparam logic [EVT_W-1:0] CntMax  = '1;
    localparam logic [EVT_W-1:0] CntOne  = EVT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] run_q, run_d, run_inc;
    logic [CNT_W-1:0] run_len_q, run_len_d;
    logic [EVT_W-1:0] det_count_q;
    logic             det_hit;

    // Cannot wrap: run_q never exceeds MAX_RUN+1 and 2^CNT_W > MAX_RUN+1.
    assign run_inc = run_q + RunOne;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            run_q     <= '0;
            run_len_q <= '0;
        end else if (en) begin
            state_q   <= state_d;
            run_q     <= run_d;
            run_len_q <= run_len_d;
        end
    end

    always_comb begin
        state_d   = StIdle;
        run_d     = '0;
        run_len_d = run_len_q;
        det_hit   = 1'b0;
        case (state_q)
            StIdle, StDetected: begin
                if (x) begin
                    run_d   = RunOne;
                    state_d = (MIN_RUN == 1) ? StArmed : StCount;
                end
            end
            StCount: begin
                if (x) begin
                    run_d   = run_inc;
                    state_d = (run_inc >= MinRun) ? StArmed : StCount;
                end
            end
            StArmed: begin
                if (x) begin
                    run_d   = run_inc;
                    state_d = (run_inc > MaxRun) ? StOver : StArmed;
                end else begin
                    state_d   = StDetected;
                    run_len_d = run_q;
                    det_hit   = 1'b1;
                end
            end
            StOver: begin
                if (x) begin
                    state_d = StOver;
                    run_d   = MaxRun + RunOne;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Clear beats a coincident increment.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            det_count_q <= '0;
        end else if (en && det_hit && (det_count_q != CntMax)) begin
            det_count_q <= det_count_q + CntOne;
        end
    end

    always_comb begin
        detected  = (state_q == StDetected);
        overrun   = (state_q == StOver);
        state     = state_q;
        run_len   = run_len_q;
        det_count = det_count_q;
    end

endmodule

// File: tb/tb_run_detector_param.sv
// Three parameterisations of run_detector_param share one stimulus stream and are
// checked against a run-length reference model, a vector table and directed sequences.
module tb_run_detector_param;

    logic clk = 1'b0;
    logic rst, en, x, clr_cnt;

    always #5 clk = ~clk;

    // a: MIN 3 / MAX 5 / EVT 8; b: same with EVT 2; c: MIN 1 / MAX 5 / EVT 8
    logic       a_det, a_ov, b_det, b_ov, c_det, c_ov;
    logic [3:0] a_len, b_len, c_len;
    logic [7:0] a_cnt, c_cnt;
    logic [1:0] b_cnt;
    logic [2:0] a_st, b_st, c_st;

    run_detector_param #(.MIN_RUN(3), .MAX_RUN(5), .CNT_W(4), .EVT_W(8)) dut_a (
        .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr_cnt),
        .detected(a_det), .overrun(a_ov), .run_len(a_len), .det_count(a_cnt), .state(a_st)
    );
    run_detector_param #(.MIN_RUN(3), .MAX_RUN(5), .CNT_W(4), .EVT_W(2)) dut_b (
        .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr_cnt),
        .detected(b_det), .overrun(b_ov), .run_len(b_len), .det_count(b_cnt), .state(b_st)
    );
    run_detector_param #(.MIN_RUN(1), .MAX_RUN(5), .CNT_W(4), .EVT_W(8)) dut_c (
        .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr_cnt),
        .detected(c_det), .overrun(c_ov), .run_len(c_len), .det_count(c_cnt), .state(c_st)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: length of the current run of ones, plus a "just detected" flag.
    int p_min [3];
    int p_max [3];
    int p_cmax[3];
    int m_run [3];
    int m_len [3];
    int m_cnt [3];
    bit m_det [3];

    task automatic cmp(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0d, want %0d", name, cyc, got, want);
        end
    endtask

    task automatic model_update(input bit r, input bit e, input bit xi, input bit c);
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                m_run[i] = 0;
                m_len[i] = 0;
                m_cnt[i] = 0;
                m_det[i] = 0;
            end else begin
                if (e) begin
                    if (xi) begin
                        m_det[i] = 0;
                        m_run[i] = (m_run[i] + 1 > p_max[i] + 1) ? p_max[i] + 1 : m_run[i] + 1;
                    end else begin
                        m_det[i] = (m_run[i] >= p_min[i]) && (m_run[i] <= p_max[i]);
                        if (m_det[i]) begin
                            m_len[i] = m_run[i];
                            if (m_cnt[i] < p_cmax[i]) m_cnt[i]++;
                        end
                        m_run[i] = 0;
                    end
                end
                if (c) m_cnt[i] = 0;
            end
        end
    endtask

    function automatic int model_state(input int i);
        if (m_det[i])             return 4;
        if (m_run[i] == 0)        return 0;
        if (m_run[i] > p_max[i])  return 3;
        if (m_run[i] >= p_min[i]) return 2;
        return 1;
    endfunction

    task automatic cmp_inst(input int i, input int st, input int d, input int o, input int l,
                            input int c);
        int ms;
        ms = model_state(i);
        cmp($sformatf("inst%0d state", i), st, ms);
        cmp($sformatf("inst%0d detected", i), d, (ms == 4) ? 1 : 0);
        cmp($sformatf("inst%0d overrun", i), o, (ms == 3) ? 1 : 0);
        cmp($sformatf("inst%0d run_len", i), l, m_len[i]);
        cmp($sformatf("inst%0d det_count", i), c, m_cnt[i]);
    endtask

    task automatic step(input bit r, input bit e, input bit xi, input bit c);
        rst = r; en = e; x = xi; clr_cnt = c;
        @(posedge clk);
        cyc++;
        model_update(r, e, xi, c);
        #1;
        cmp_inst(0, int'(a_st), int'(a_det), int'(a_ov), int'(a_len), int'(a_cnt));
        cmp_inst(1, int'(b_st), int'(b_det), int'(b_ov), int'(b_len), int'(b_cnt));
        cmp_inst(2, int'(c_st), int'(c_det), int'(c_ov), int'(c_len), int'(c_cnt));
    endtask

    task automatic detect_run(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    typedef struct {
        bit r, e, xi, c;
        int st, d, o, l, n;
    } vec_t;

    function automatic vec_t mk(input bit r, input bit e, input bit xi, input bit c,
                                input int st, input int d, input int o, input int l,
                                input int n);
        vec_t v;
        v.r = r; v.e = e; v.xi = xi; v.c = c;
        v.st = st; v.d = d; v.o = o; v.l = l; v.n = n;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        p_min  = '{3, 3, 1};
        p_max  = '{5, 5, 5};
        p_cmax = '{255, 3, 255};
        m_run  = '{0, 0, 0};
        m_len  = '{0, 0, 0};
        m_cnt  = '{0, 0, 0};
        m_det  = '{0, 0, 0};
        rst = 1'b1; en = 1'b1; x = 1'b1; clr_cnt = 1'b0;

        // Expected values for instance a (MIN 3, MAX 5): rst en x clr | st det ov len cnt
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 2, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 4, 1, 0, 3, 1));
        tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 3, 1));
        tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 3, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 3, 1));
        for (int k = 1; k <= 5; k++)
            tbl.push_back(mk(0, 1, 1, 0, (k < 3) ? 1 : 2, 0, 0, 3, 1));
        tbl.push_back(mk(0, 1, 1, 0, 3, 0, 1, 3, 1));
        tbl.push_back(mk(0, 1, 1, 0, 3, 0, 1, 3, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 3, 1));
        tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 3, 1));
        tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 3, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 3, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 3, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 3, 1));
        tbl.push_back(mk(0, 1, 1, 0, 2, 0, 0, 3, 1));
        tbl.push_back(mk(0, 1, 1, 0, 2, 0, 0, 3, 1));
        tbl.push_back(mk(0, 1, 0, 0, 4, 1, 0, 4, 2));
        tbl.push_back(mk(0, 0, 1, 0, 4, 1, 0, 4, 2));
        tbl.push_back(mk(0, 0, 0, 0, 4, 1, 0, 4, 2));
        tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 4, 2));
        tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 4, 2));
        tbl.push_back(mk(0, 1, 1, 0, 2, 0, 0, 4, 2));
        tbl.push_back(mk(0, 1, 0, 0, 4, 1, 0, 3, 3));
        tbl.push_back(mk(0, 0, 0, 1, 4, 1, 0, 3, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 3, 0));

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].e, tbl[i].xi, tbl[i].c);
            cmp($sformatf("tbl%0d state", i), int'(a_st), tbl[i].st);
            cmp($sformatf("tbl%0d detected", i), int'(a_det), tbl[i].d);
            cmp($sformatf("tbl%0d overrun", i), int'(a_ov), tbl[i].o);
            cmp($sformatf("tbl%0d run_len", i), int'(a_len), tbl[i].l);
            cmp($sformatf("tbl%0d det_count", i), int'(a_cnt), tbl[i].n);
        end

        // Saturation with EVT_W=2, then clear on the edge of another detection.
        for (int k = 0; k < 5; k++) detect_run(3);
        cmp("sat b det_count", int'(b_cnt), 3);
        cmp("sat a det_count", int'(a_cnt), 5);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        cmp("clr b det_count", int'(b_cnt), 0);
        cmp("clr a det_count", int'(a_cnt), 0);
        cmp("clr b run_len", int'(b_len), 4);
        cmp("clr b detected", int'(b_det), 1);

        // MIN_RUN=1 corner, then reset in the middle of a run.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        cmp("min1 c state armed", int'(c_st), 2);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        cmp("min1 c detected", int'(c_det), 1);
        cmp("min1 c run_len", int'(c_len), 1);
        cmp("min1 a detected", int'(a_det), 0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        cmp("rst mid-run c state", int'(c_st), 0);
        cmp("rst mid-run c detected", int'(c_det), 0);
        cmp("rst mid-run c det_count", int'(c_cnt), 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        cmp("after rst c detected", int'(c_det), 0);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < 80),
                 ($urandom_range(0, 99) < 68),
                 ($urandom_range(0, 99) < 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
